mem_wb_pipe: RTL and testbench

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

---
 rtl/mem_wb_pipe_if.sv | 40 ++++
 rtl/mem_wb_pipe.sv | 71 +++++++
 tb/tb_mem_wb_pipe.sv | 126 ++++++++++++
 3 files changed

// File: rtl/mem_wb_pipe_if.sv
// mem_wb_pipe_if: MEM-side inputs and registered WB-side outputs of the MEM/WB pipeline register (optional HI/LO via MEM_WB_HILO_EN)
interface mem_wb_pipe_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_CH = 1
);
  logic                     mem_valid;
  logic [NUM_CH*ADDR_W-1:0] mem_wd;
  logic [NUM_CH*DATA_W-1:0] mem_wdata;
  logic [NUM_CH-1:0]        mem_wreg;
  logic                     wb_valid;
  logic [NUM_CH*ADDR_W-1:0] wb_wd;
  logic [NUM_CH*DATA_W-1:0] wb_wdata;
  logic [NUM_CH-1:0]        wb_wreg;
`ifdef MEM_WB_HILO_EN
  logic                     mem_whilo;
  logic [DATA_W-1:0]        mem_hi;
  logic [DATA_W-1:0]        mem_lo;
  logic                     wb_whilo;
  logic [DATA_W-1:0]        wb_hi;
  logic [DATA_W-1:0]        wb_lo;
  modport master (
    output mem_valid, mem_wd, mem_wdata, mem_wreg, mem_whilo, mem_hi, mem_lo,
    input  wb_valid, wb_wd, wb_wdata, wb_wreg, wb_whilo, wb_hi, wb_lo
  );
  modport slave (
    input  mem_valid, mem_wd, mem_wdata, mem_wreg, mem_whilo, mem_hi, mem_lo,
    output wb_valid, wb_wd, wb_wdata, wb_wreg, wb_whilo, wb_hi, wb_lo
  );
`else
  modport master (
    output mem_valid, mem_wd, mem_wdata, mem_wreg,
    input  wb_valid, wb_wd, wb_wdata, wb_wreg
  );
  modport slave (
    input  mem_valid, mem_wd, mem_wdata, mem_wreg,
    output wb_valid, wb_wd, wb_wdata, wb_wreg
  );
`endif
endinterface

// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe: MEM->WB pipeline register with flush/bubble/hold/advance and retire counter (HI/LO path under MEM_WB_HILO_EN)
module mem_wb_pipe #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_CH  = 1,
  parameter int STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [STALL_W-1:0] stall,
  input  logic               flush,
  mem_wb_pipe_if.slave       bus,
  output logic [31:0]        retire_cnt
);
  logic                     nop, adv;
  logic                     valid_n;
  logic [NUM_CH*ADDR_W-1:0] wd_n;
  logic [NUM_CH*DATA_W-1:0] wdata_n;
  logic [NUM_CH-1:0]        wreg_n;
  logic [31:0]              cnt, cnt_n;
  // flush or bubble loads NOP; stall[4]=0 advances regardless of stall[5]; otherwise hold
  assign nop = flush | (stall[4] & ~stall[5]);
  assign adv = ~flush & ~stall[4];
  assign retire_cnt = cnt;
  // next WB state selected by stage priority; invalid instructions never write the regfile
  always_comb begin
    valid_n = nop ? 1'b0 : adv ? bus.mem_valid : bus.wb_valid;
    wd_n    = nop ? '0 : adv ? bus.mem_wd : bus.wb_wd;
    wdata_n = nop ? '0 : adv ? bus.mem_wdata : bus.wb_wdata;
    wreg_n  = nop ? '0 : adv ? (bus.mem_valid ? bus.mem_wreg : '0) : bus.wb_wreg;
    cnt_n   = (adv && bus.mem_valid) ? cnt + 32'd1 : cnt;
  end
  // WB register bank with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_valid <= 1'b0;
      bus.wb_wd    <= '0;
      bus.wb_wdata <= '0;
      bus.wb_wreg  <= '0;
      cnt          <= '0;
    end else begin
      bus.wb_valid <= valid_n;
      bus.wb_wd    <= wd_n;
      bus.wb_wdata <= wdata_n;
      bus.wb_wreg  <= wreg_n;
      cnt          <= cnt_n;
    end
  end
`ifdef MEM_WB_HILO_EN
  logic              whilo_n;
  logic [DATA_W-1:0] hi_n, lo_n;
  // HI/LO follow the same stage rules as the register-write channels
  always_comb begin
    whilo_n = nop ? 1'b0 : adv ? (bus.mem_valid & bus.mem_whilo) : bus.wb_whilo;
    hi_n    = nop ? '0 : adv ? bus.mem_hi : bus.wb_hi;
    lo_n    = nop ? '0 : adv ? bus.mem_lo : bus.wb_lo;
  end
  // HI/LO register with asynchronous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wb_whilo <= 1'b0;
      bus.wb_hi    <= '0;
      bus.wb_lo    <= '0;
    end else begin
      bus.wb_whilo <= whilo_n;
      bus.wb_hi    <= hi_n;
      bus.wb_lo    <= lo_n;
    end
  end
`endif
endmodule

// File: tb/tb_mem_wb_pipe.sv
// tb_mem_wb_pipe: directed self-checking bench for mem_wb_pipe with NUM_CH=2 (HI/LO steps under MEM_WB_HILO_EN)
module tb_mem_wb_pipe;
  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] stall;
  logic       flush;
  logic [31:0] retire_cnt;
  int checks = 0;
  int errors = 0;
  mem_wb_pipe_if #(.DATA_W(32), .ADDR_W(5), .NUM_CH(2)) bus ();
  mem_wb_pipe #(.DATA_W(32), .ADDR_W(5), .NUM_CH(2), .STALL_W(6)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .bus(bus), .retire_cnt(retire_cnt)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_wb(input string tag, input logic [9:0] wd, input logic [63:0] wdata,
                        input logic [1:0] wreg, input logic valid, input logic [31:0] cnt);
    chk({tag, ".wd"}, 64'(bus.wb_wd), 64'(wd));
    chk({tag, ".wdata"}, bus.wb_wdata, wdata);
    chk({tag, ".wreg"}, 64'(bus.wb_wreg), 64'(wreg));
    chk({tag, ".valid"}, 64'(bus.wb_valid), 64'(valid));
    chk({tag, ".cnt"}, 64'(retire_cnt), 64'(cnt));
  endtask
  task automatic drive(input logic valid, input logic [9:0] wd, input logic [63:0] wdata, input logic [1:0] wreg);
    bus.mem_valid = valid;
    bus.mem_wd    = wd;
    bus.mem_wdata = wdata;
    bus.mem_wreg  = wreg;
  endtask
  initial begin
    rst = 1'b1;
    stall = '0;
    flush = 1'b0;
    drive(1'b0, '0, '0, '0);
`ifdef MEM_WB_HILO_EN
    bus.mem_whilo = 1'b0;
    bus.mem_hi = '0;
    bus.mem_lo = '0;
`endif
    #2;
    chk_wb("reset", 10'h000, 64'h0, 2'b00, 1'b0, 32'd0);
    step();
    rst = 1'b0;
    drive(1'b1, {5'd3, 5'd7}, {32'hA5A5_0001, 32'h0000_BEEF}, 2'b11);
    step();
    chk_wb("advance", 10'h067, 64'hA5A5_0001_0000_BEEF, 2'b11, 1'b1, 32'd1);
    stall = 6'b010000;
    drive(1'b1, {5'd1, 5'd1}, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11);
    step();
    chk_wb("bubble", 10'h000, 64'h0, 2'b00, 1'b0, 32'd1);
    stall = 6'b000000;
    drive(1'b1, {5'd3, 5'd7}, {32'hA5A5_0001, 32'h0000_BEEF}, 2'b11);
    step();
    chk_wb("readvance", 10'h067, 64'hA5A5_0001_0000_BEEF, 2'b11, 1'b1, 32'd2);
    stall = 6'b110000;
    drive(1'b1, {5'd31, 5'd30}, 64'h1111_2222_3333_4444, 2'b01);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_wb("hold", 10'h067, 64'hA5A5_0001_0000_BEEF, 2'b11, 1'b1, 32'd2);
    end
    stall = 6'b100000;
    drive(1'b1, {5'd1, 5'd2}, {32'h1111_1111, 32'h2222_2222}, 2'b01);
    step();
    chk_wb("illegal_adv", 10'h022, 64'h1111_1111_2222_2222, 2'b01, 1'b1, 32'd3);
    stall = 6'b110000;
    flush = 1'b1;
    drive(1'b1, {5'd4, 5'd5}, 64'hDEAD_BEEF_CAFE_F00D, 2'b11);
    step();
    chk_wb("flush", 10'h000, 64'h0, 2'b00, 1'b0, 32'd3);
    stall = 6'b000000;
    flush = 1'b0;
    drive(1'b0, {5'd9, 5'd9}, 64'h0000_0009_0000_0009, 2'b11);
    step();
    chk_wb("invalid", 10'h129, 64'h0000_0009_0000_0009, 2'b00, 1'b0, 32'd3);
    force dut.cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cnt;
    #1;
    chk("preload.cnt", 64'(retire_cnt), 64'hFFFF_FFFF);
    drive(1'b1, {5'd6, 5'd8}, 64'h0000_0006_0000_0008, 2'b10);
    step();
    chk_wb("wrap", 10'h0C8, 64'h0000_0006_0000_0008, 2'b10, 1'b1, 32'd0);
    stall = 6'b110000;
    #2;
    rst = 1'b1;
    #1;
    chk_wb("async_rst", 10'h000, 64'h0, 2'b00, 1'b0, 32'd0);
    step();
    rst = 1'b0;
    step();
    chk_wb("hold_after_rst", 10'h000, 64'h0, 2'b00, 1'b0, 32'd0);
    stall = 6'b000000;
    step();
    chk_wb("adv_after_rst", 10'h0C8, 64'h0000_0006_0000_0008, 2'b10, 1'b1, 32'd1);
`ifdef MEM_WB_HILO_EN
    bus.mem_whilo = 1'b1;
    bus.mem_hi = 32'h1234_5678;
    bus.mem_lo = 32'h9ABC_DEF0;
    step();
    chk("hilo.whilo", 64'(bus.wb_whilo), 64'h1);
    chk("hilo.hi", 64'(bus.wb_hi), 64'h1234_5678);
    chk("hilo.lo", 64'(bus.wb_lo), 64'h9ABC_DEF0);
    stall = 6'b010000;
    step();
    chk("hilo_bubble.whilo", 64'(bus.wb_whilo), 64'h0);
    chk("hilo_bubble.hi", 64'(bus.wb_hi), 64'h0);
    stall = 6'b000000;
    bus.mem_valid = 1'b0;
    step();
    chk("hilo_invalid.whilo", 64'(bus.wb_whilo), 64'h0);
    chk("hilo_invalid.hi", 64'(bus.wb_hi), 64'h1234_5678);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
